seg7_scan_driver: RTL and testbench

Display back-end for the PWM generator board. Periodically requests a conversion from the BCD converter, captures the hundreds/tens/units digits on the converter's ready edge, and time-multiplexes them onto a 3-digit common-anode seven-segment display with leading-zero blanking. It sits directly downstream of the BCD converter and drives its enable, closing the loop that shows the current PWM reference value.

---
 rtl/seg7_scan_driver.sv | 193 +++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Requests a conversion from the BCD converter at reset release and at every
//   frame start. It captures hundreds/tens/units on a fresh rising edge of rdy
//   and time-multiplexes the captured digits onto a 3-digit seven-segment
//   display. Leading zeros are blanked, and all anodes are off for the first
//   cycle of each dwell to prevent ghosting.
// Ports
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active low
//   rdy      : converter result-ready
//   fdig     : hundreds digit (BCD)
//   sdig     : tens digit (BCD)
//   tdig     : units digit (BCD)
//   conv_ena : conversion request to the converter
//   seg      : segments {g,f,e,d,c,b,a}, pin polarity set by SEG_ACTIVE_LOW
//   an       : digit enables {hundreds,tens,units}, pin polarity set by AN_ACTIVE_LOW
//   err      : sticky conversion-timeout flag, cleared by the next good capture
module seg7_scan_driver #(
  parameter int unsigned REFRESH_BITS   = 16,
  parameter int unsigned TIMEOUT_BITS   = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [3:0] fdig,
  input  logic [3:0] sdig,
  input  logic [3:0] tdig,
  output logic       conv_ena,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW  ? 3'b111 : 3'b000;

  logic [0:0]              state;
  logic                    boot;
  logic                    rdy_q;
  logic [TIMEOUT_BITS-1:0] tmo_cnt;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              scan_idx;

  // lat_* holds the converter result; shw_* is the snapshot the scan reads.
  logic [3:0] lat_h, lat_t, lat_u;
  logic [3:0] shw_h, shw_t, shw_u;

  logic       refresh_tc;
  logic       frame_start;
  logic       rdy_rise;
  logic       req_start;
  logic [3:0] cur_digit;
  logic       cur_blank;
  logic [2:0] an_onehot;
  logic [6:0] seg_act;
  logic [2:0] an_act;
  logic [6:0] seg_pin;
  logic [2:0] an_pin;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign refresh_tc  = &refresh_cnt;
  assign frame_start = refresh_tc && (scan_idx == 2'd2);
  assign rdy_rise    = rdy & ~rdy_q;
  assign req_start   = boot | frame_start;

  always_comb begin
    cur_digit = shw_u;
    cur_blank = 1'b0;
    an_onehot = 3'b001;
    case (scan_idx)
      2'd1: begin
        cur_digit = shw_t;
        cur_blank = (shw_h == 4'd0) && (shw_t == 4'd0);
        an_onehot = 3'b010;
      end
      2'd2: begin
        cur_digit = shw_h;
        cur_blank = (shw_h == 4'd0);
        an_onehot = 3'b100;
      end
      default: begin
        cur_digit = shw_u;
        cur_blank = 1'b0;
        an_onehot = 3'b001;
      end
    endcase

    // Count 0 of every dwell drives everything dark to prevent ghosting.
    if (refresh_cnt == '0) begin
      seg_act = '0;
      an_act  = '0;
    end else begin
      seg_act = cur_blank ? 7'h00 : decode(cur_digit);
      an_act  = an_onehot;
    end

    seg_pin = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    an_pin  = AN_ACTIVE_LOW  ? ~an_act  : an_act;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      boot        <= 1'b1;
      rdy_q       <= 1'b0;
      tmo_cnt     <= '0;
      refresh_cnt <= '0;
      scan_idx    <= 2'd0;
      lat_h       <= '0;
      lat_t       <= '0;
      lat_u       <= '0;
      shw_h       <= '0;
      shw_t       <= '0;
      shw_u       <= '0;
      conv_ena    <= 1'b0;
      err         <= 1'b0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
    end else begin
      boot        <= 1'b0;
      rdy_q       <= rdy;
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      if (refresh_tc) begin
        scan_idx <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
      end

      // Snapshot at the dark cycle, so a capture mid-dwell shows up only
      // from the next dwell onward.
      if (refresh_cnt == '0) begin
        shw_h <= lat_h;
        shw_t <= lat_t;
        shw_u <= lat_u;
      end

      seg <= seg_pin;
      an  <= an_pin;

      case (state)
        ST_IDLE: begin
          if (req_start) begin
            state    <= ST_REQ;
            conv_ena <= 1'b1;
            tmo_cnt  <= TIMEOUT_BITS'(1);
          end
        end
        ST_REQ: begin
          // tmo_cnt holds the number of cycles already spent in REQ.
          if (rdy_rise) begin
            lat_h    <= fdig;
            lat_t    <= sdig;
            lat_u    <= tdig;
            err      <= 1'b0;
            conv_ena <= 1'b0;
            state    <= ST_IDLE;
          end else if (tmo_cnt == '1) begin
            err      <= 1'b1;
            conv_ena <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TIMEOUT_BITS'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          conv_ena <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver: edge-level reference model with scoreboard queue.
module tb_seg7_scan_driver;

  localparam int RB    = 2;
  localparam int TB    = 3;
  localparam int D     = 1 << RB;
  localparam int FRAME = 3 * D;
  localparam int TMO   = (1 << TB) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] fdig = '0;
  logic [3:0] sdig = '0;
  logic [3:0] tdig = '0;
  logic       conv_ena;
  logic [6:0] seg;
  logic [2:0] an;
  logic       err;

  seg7_scan_driver #(
    .REFRESH_BITS  (RB),
    .TIMEOUT_BITS  (TB),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .fdig    (fdig),
    .sdig    (sdig),
    .tdig    (tdig),
    .conv_ena(conv_ena),
    .seg     (seg),
    .an      (an),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] an;
    logic       conv;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference model state; digit arrays are indexed 0=units, 1=tens, 2=hundreds.
  logic [6:0] seg_tab [16];
  int         e;
  bit         m_req;
  int         req_start;
  bit         m_err;
  bit         prev_rdy;
  logic [3:0] lat   [3];
  logic [3:0] shown [3];
  exp_t       mx;
  int         p, cnt, idx;
  bit         blank;

  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  always @(posedge clk) begin
    if (!rst) begin
      e = 0; m_req = 0; m_err = 0; prev_rdy = 0;
      for (int i = 0; i < 3; i++) begin
        lat[i]   = '0;
        shown[i] = '0;
      end
      mx = '{seg: 7'h7F, an: 3'b111, conv: 1'b0, err: 1'b0};
    end else begin
      e++;
      p   = e - 1;
      cnt = p % D;
      idx = (p / D) % 3;
      if (cnt == 0) begin
        mx.seg = 7'h7F;
        mx.an  = 3'b111;
        for (int i = 0; i < 3; i++) shown[i] = lat[i];
      end else begin
        blank = (idx == 2 && shown[2] == 0) ||
                (idx == 1 && shown[2] == 0 && shown[1] == 0);
        mx.seg = blank ? 7'h7F : ~seg_tab[shown[idx]];
        mx.an  = ~(3'b001 << idx);
      end
      if (m_req) begin
        if (rdy && !prev_rdy) begin
          lat[0] = tdig; lat[1] = sdig; lat[2] = fdig;
          m_err = 0; m_req = 0;
        end else if (e - req_start == TMO) begin
          m_err = 1; m_req = 0;
        end
      end else if (e == 1 || e % FRAME == 0) begin
        m_req = 1; req_start = e;
      end
      prev_rdy = rdy;
      mx.conv  = m_req;
      mx.err   = m_err;
    end
    exp_q.push_back(mx);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("seg",      {1'b0, seg},      {1'b0, x.seg});
      chk("an",       {5'b0, an},       {5'b0, x.an});
      chk("conv_ena", {7'b0, conv_ena}, {7'b0, x.conv});
      chk("err",      {7'b0, err},      {7'b0, x.err});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 4 * FRAME && !m_req; i++) @(negedge clk);
    if (!m_req) begin
      compared++;
      mismatched++;
      $display("FAIL wait_req: no request within %0d cycles", 4 * FRAME);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4 * FRAME && m_req; i++) @(negedge clk);
  endtask

  task automatic capture(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    rdy = 1'b0;
    wait_req();
    fdig = h; sdig = t; tdig = u;
    tick(1);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    tick(3);
    rst = 1'b1;

    capture(4'd2, 4'd5, 4'd5);
    tick(2 * FRAME);
    capture(4'd0, 4'd0, 4'd7);
    tick(2 * FRAME);
    capture(4'd0, 4'd4, 4'd0);
    tick(2 * FRAME);

    // Timeout: leave rdy low through a full request window.
    rdy = 1'b0;
    fdig = 4'd9; sdig = 4'd9; tdig = 4'd9;
    tick(2 * FRAME);
    capture(4'd1, 4'd2, 4'd3);
    tick(2 * FRAME);

    // Stale rdy: high across request entry, then a fresh 0->1 edge.
    wait_idle();
    fdig = 4'd0; sdig = 4'd12; tdig = 4'd3;
    rdy = 1'b1;
    wait_req();
    tick(2);
    rdy = 1'b0;
    tick(1);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    tick(2 * FRAME);

    // Reset lands on the same edge as a rising rdy during a request.
    wait_idle();
    wait_req();
    fdig = 4'd8; sdig = 4'd8; tdig = 4'd8;
    rdy = 1'b1;
    rst = 1'b0;
    tick(2);
    rdy = 1'b0;
    rst = 1'b1;
    tick(2 * FRAME);

    // Random traffic: digits biased toward zero, bursty rdy, rare resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        fdig = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        sdig = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        tdig = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 5) == 0) rdy = ~rdy;
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst = 1'b1;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
